// File: rtl/run_sequencer.sv
// run_sequencer: launches one processor run at a time and reports its outcome.
// A request selects one of three program start addresses (program 3 is
// illegal and answered at once). The processor is released from Start for
// the duration of the run, and the run ends on done, timeout or abort. The
// result is then held on the response port until it is consumed.
module run_sequencer #(
  parameter logic [7:0]  PROG0_ADDR   = 8'h00,
  parameter logic [7:0]  PROG1_ADDR   = 8'h28,
  parameter logic [7:0]  PROG2_ADDR   = 8'h50,
  parameter int unsigned START_CYCLES = 2,
  parameter logic [15:0] TIMEOUT      = 16'd4000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  input  logic [1:0]  req_prog,
  output logic        req_ready,
  output logic        cpu_start,
  output logic [7:0]  cpu_start_addr,
  input  logic        cpu_done,
  input  logic        abort,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_prog,
  output logic [15:0] rsp_cycles,
  output logic [1:0]  rsp_status,
  output logic        busy,
  output logic [7:0]  run_count
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Response status codes
  localparam logic [1:0] STAT_DONE    = 2'b00;
  localparam logic [1:0] STAT_TIMEOUT = 2'b01;
  localparam logic [1:0] STAT_ABORT   = 2'b10;
  localparam logic [1:0] STAT_ILLEGAL = 2'b11;

  // START is left when the 4-bit counter reaches its final value
  localparam logic [3:0] START_LAST = 4'(START_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  start_cnt_q, start_cnt_d;
  logic [15:0] cyc_cnt_q, cyc_cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic [1:0]  rsp_prog_q, rsp_prog_d;
  logic [15:0] rsp_cycles_q, rsp_cycles_d;
  logic [1:0]  rsp_status_q, rsp_status_d;
  logic [7:0]  run_count_q, run_count_d;

  logic        req_legal;
  logic [7:0]  mapped_addr;

  // Program index to start address; program 3 has no address
  always_comb begin
    req_legal   = 1'b1;
    mapped_addr = PROG0_ADDR;
    case (req_prog)
      2'd0:    mapped_addr = PROG0_ADDR;
      2'd1:    mapped_addr = PROG1_ADDR;
      2'd2:    mapped_addr = PROG2_ADDR;
      default: begin
        mapped_addr = addr_q;
        req_legal   = 1'b0;
      end
    endcase
  end

  // Next-state and datapath updates; abort beats done, done beats timeout
  always_comb begin
    state_d      = state_q;
    start_cnt_d  = start_cnt_q;
    cyc_cnt_d    = cyc_cnt_q;
    addr_d       = addr_q;
    rsp_prog_d   = rsp_prog_q;
    rsp_cycles_d = rsp_cycles_q;
    rsp_status_d = rsp_status_q;
    run_count_d  = run_count_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rsp_prog_d  = req_prog;
          start_cnt_d = 4'd0;
          cyc_cnt_d   = 16'd0;
          if (req_legal) begin
            addr_d  = mapped_addr;
            state_d = ST_START;
          end else begin
            // Illegal program: answer immediately, processor untouched
            rsp_status_d = STAT_ILLEGAL;
            rsp_cycles_d = 16'd0;
            state_d      = ST_RESP;
          end
        end
      end
      ST_START: begin
        if (abort) begin
          rsp_status_d = STAT_ABORT;
          rsp_cycles_d = 16'd0;
          state_d      = ST_RESP;
        end else if (start_cnt_q == START_LAST) begin
          // The first RUN cycle already counts as cycle 1
          start_cnt_d = 4'd0;
          cyc_cnt_d   = 16'd1;
          state_d     = ST_RUN;
        end else begin
          start_cnt_d = start_cnt_q + 4'd1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          rsp_status_d = STAT_ABORT;
          rsp_cycles_d = cyc_cnt_q;
          state_d      = ST_RESP;
        end else if (cpu_done) begin
          rsp_status_d = STAT_DONE;
          rsp_cycles_d = cyc_cnt_q;
          state_d      = ST_RESP;
        end else if (cyc_cnt_q == TIMEOUT) begin
          rsp_status_d = STAT_TIMEOUT;
          rsp_cycles_d = TIMEOUT;
          state_d      = ST_RESP;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          run_count_d = run_count_q + 8'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and counters
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      start_cnt_q <= 4'd0;
      cyc_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      start_cnt_q <= start_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
    end
  end

  // Start address, held until the next legal acceptance
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q <= 8'h00;
    end else begin
      addr_q <= addr_d;
    end
  end

  // Response fields and completed-run counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rsp_prog_q   <= 2'd0;
      rsp_cycles_q <= 16'd0;
      rsp_status_q <= 2'b00;
      run_count_q  <= 8'd0;
    end else begin
      rsp_prog_q   <= rsp_prog_d;
      rsp_cycles_q <= rsp_cycles_d;
      rsp_status_q <= rsp_status_d;
      run_count_q  <= run_count_d;
    end
  end

  // Handshake outputs decode from state only; the processor is parked outside RUN
  assign req_ready      = (state_q == ST_IDLE);
  assign rsp_valid      = (state_q == ST_RESP);
  assign busy           = (state_q == ST_START) || (state_q == ST_RUN);
  assign cpu_start      = (state_q != ST_RUN);
  assign cpu_start_addr = addr_q;
  assign rsp_prog       = rsp_prog_q;
  assign rsp_cycles     = rsp_cycles_q;
  assign rsp_status     = rsp_status_q;
  assign run_count      = run_count_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Testbench for run_sequencer: table-driven runs with a response scoreboard,
// plus hand-written stall, mid-run reset and counter-wrap sequences.
module tb_run_sequencer;

  localparam int          START_CYCLES = 2;
  localparam logic [15:0] TIMEOUT      = 16'd10;

  logic        CLK;
  logic        RST_N;
  logic        req_valid;
  logic [1:0]  req_prog;
  logic        req_ready;
  logic        cpu_start;
  logic [7:0]  cpu_start_addr;
  logic        cpu_done;
  logic        abort;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_prog;
  logic [15:0] rsp_cycles;
  logic [1:0]  rsp_status;
  logic        busy;
  logic [7:0]  run_count;

  run_sequencer #(
    .START_CYCLES(START_CYCLES),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .req_valid(req_valid),
    .req_prog(req_prog),
    .req_ready(req_ready),
    .cpu_start(cpu_start),
    .cpu_start_addr(cpu_start_addr),
    .cpu_done(cpu_done),
    .abort(abort),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_prog(rsp_prog),
    .rsp_cycles(rsp_cycles),
    .rsp_status(rsp_status),
    .busy(busy),
    .run_count(run_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // One run: done_k = RUN cycle raising cpu_done (0 = never), abort_c = cycle
  // after acceptance raising abort (0 = never), lat = cycle of rsp_valid.
  typedef struct {
    logic [1:0]  prog;
    int          done_k;
    bit          done_start;
    int          abort_c;
    bit          abort_idle;
    logic [1:0]  status;
    logic [15:0] cycles;
    int          lat;
  } vec_t;

  typedef struct {
    logic [1:0]  prog;
    logic [1:0]  status;
    logic [15:0] cycles;
  } rsp_t;

  rsp_t       sb[$];
  vec_t       tbl[11];
  int         checks = 0;
  int         errors = 0;
  int         txn = 0;
  logic [7:0] exp_addr;
  logic [7:0] exp_runs;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] map_addr(input logic [1:0] p);
    case (p)
      2'd1:    return 8'h28;
      2'd2:    return 8'h50;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk_reset(input string name);
    chk(name, 32'({cpu_start, req_ready, rsp_valid, busy}), 32'(4'b1100));
    chk({name, "_addr"}, 32'(cpu_start_addr), 32'd0);
    chk({name, "_rsp"}, 32'({rsp_prog, rsp_status, rsp_cycles}), 32'd0);
    chk({name, "_runs"}, 32'(run_count), 32'd0);
  endtask

  // Drive a request in IDLE; the expected response enters the scoreboard here
  task automatic issue(input vec_t v, input bit track);
    rsp_t e;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_prog  = v.prog;
    abort     = v.abort_idle;
    if (track) begin
      e.prog   = v.prog;
      e.status = v.status;
      e.cycles = v.cycles;
      sb.push_back(e);
    end
    tick();
    req_valid = 1'b0;
    abort     = 1'b0;
    if (v.prog != 2'd3) exp_addr = map_addr(v.prog);
  endtask

  // From cycle 1 after acceptance: drive done/abort, wait for the response, score it
  task automatic run_body(input vec_t v);
    int   c;
    bit   got;
    rsp_t e;
    got = 1'b0;
    for (c = 1; c <= 40; c++) begin
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      chk("inflight", 32'({cpu_start, busy, req_ready, rsp_valid, cpu_start_addr}),
          32'({(c <= START_CYCLES), 1'b1, 1'b0, 1'b0, exp_addr}));
      cpu_done = ((v.done_k != 0) && (c == START_CYCLES + v.done_k)) ||
                 (v.done_start && (c <= START_CYCLES));
      abort    = (v.abort_c != 0) && (c == v.abort_c);
      tick();
    end
    cpu_done = 1'b0;
    abort    = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL resp_wait: no rsp_valid within 40 cycles, required at cycle %0d", v.lat);
      if (sb.size() > 0) e = sb.pop_front();
      return;
    end
    chk("latency", 32'(c), 32'(v.lat));
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: response with empty queue, got prog %0d", rsp_prog);
      return;
    end
    e = sb.pop_front();
    chk("rsp_prog", 32'(rsp_prog), 32'(e.prog));
    chk("rsp_status", 32'(rsp_status), 32'(e.status));
    chk("rsp_cycles", 32'(rsp_cycles), 32'(e.cycles));
    chk("resp_outputs", 32'({cpu_start, busy, req_ready}), 32'(3'b100));
    chk("resp_addr", 32'(cpu_start_addr), 32'(exp_addr));
    txn++;
    $display("txn %0d: prog=%0d status=%0d cycles=%0d addr=%02h", txn, rsp_prog,
             rsp_status, rsp_cycles, cpu_start_addr);
  endtask

  // Consume the response and confirm the return to IDLE
  task automatic complete();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_runs  = exp_runs + 8'd1;
    chk("after_ack", 32'({rsp_valid, req_ready, busy, cpu_start}), 32'(4'b0101));
    chk("run_count", 32'(run_count), 32'(exp_runs));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vs;
    vec_t vt;
    vec_t vr;

    //         prog  done start abort idle  status  cycles  lat
    tbl[0]  = '{2'd1, 5,  1'b0, 0,  1'b0, 2'd0, 16'd5,  8};
    tbl[1]  = '{2'd0, 0,  1'b0, 0,  1'b0, 2'd1, 16'd10, 13};
    tbl[2]  = '{2'd2, 10, 1'b0, 0,  1'b0, 2'd0, 16'd10, 13};
    tbl[3]  = '{2'd2, 10, 1'b0, 12, 1'b0, 2'd2, 16'd10, 13};
    tbl[4]  = '{2'd0, 0,  1'b0, 1,  1'b0, 2'd2, 16'd0,  2};
    tbl[5]  = '{2'd1, 0,  1'b0, 2,  1'b0, 2'd2, 16'd0,  3};
    tbl[6]  = '{2'd0, 1,  1'b0, 0,  1'b1, 2'd0, 16'd1,  4};
    tbl[7]  = '{2'd1, 0,  1'b0, 5,  1'b0, 2'd2, 16'd3,  6};
    tbl[8]  = '{2'd3, 0,  1'b0, 0,  1'b0, 2'd3, 16'd0,  1};
    tbl[9]  = '{2'd2, 4,  1'b1, 0,  1'b0, 2'd0, 16'd4,  7};
    tbl[10] = '{2'd1, 9,  1'b0, 0,  1'b0, 2'd0, 16'd9,  12};

    RST_N     = 1'b1;
    req_valid = 1'b0;
    req_prog  = 2'd0;
    cpu_done  = 1'b0;
    abort     = 1'b0;
    rsp_ready = 1'b0;
    exp_addr  = 8'h00;
    exp_runs  = 8'd0;

    // Power-on reset
    #1 RST_N = 1'b0;
    #2 chk_reset("reset");
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    tick();

    // Table-driven runs
    for (int i = 0; i < 11; i++) begin
      issue(tbl[i], 1'b1);
      run_body(tbl[i]);
      complete();
    end

    // Response stall with a pending request, done and abort all ignored in RESP
    vs = '{2'd1, 2, 1'b0, 0, 1'b0, 2'd0, 16'd2, 5};
    vt = '{2'd2, 0, 1'b0, 0, 1'b0, 2'd1, 16'd10, 13};
    issue(vs, 1'b1);
    run_body(vs);
    req_valid = 1'b1;
    req_prog  = 2'd2;
    abort     = 1'b1;
    cpu_done  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stall", 32'({rsp_valid, req_ready, busy, rsp_prog, rsp_status, rsp_cycles}),
          32'({1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 16'd2}));
    end
    abort     = 1'b0;
    cpu_done  = 1'b0;
    rsp_ready = 1'b1;
    begin
      rsp_t e;
      e.prog   = vt.prog;
      e.status = vt.status;
      e.cycles = vt.cycles;
      sb.push_back(e);
    end
    tick();
    rsp_ready = 1'b0;
    exp_runs  = exp_runs + 8'd1;
    chk("stall_release", 32'({rsp_valid, req_ready, busy}), 32'(3'b010));
    chk("stall_runs", 32'(run_count), 32'(exp_runs));
    tick();
    req_valid = 1'b0;
    exp_addr  = 8'h50;
    chk("stall_accept", 32'({busy, req_ready, cpu_start_addr}), 32'({1'b1, 1'b0, 8'h50}));
    run_body(vt);
    complete();

    // Reset in RUN cycle 3 discards the run
    vr = '{2'd0, 0, 1'b0, 0, 1'b0, 2'd1, 16'd10, 13};
    issue(vr, 1'b0);
    repeat (4) tick();
    chk("pre_reset_run", 32'({cpu_start, busy}), 32'(2'b01));
    #2 RST_N = 1'b0;
    #1 chk_reset("midrun_reset");
    #2 RST_N = 1'b1;
    exp_runs = 8'd0;
    exp_addr = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_resp_after_reset", 32'({rsp_valid, req_ready, busy}), 32'(3'b010));
    end

    // 256 completed responses wrap the run counter back to zero
    for (int i = 0; i < 256; i++) begin
      issue(tbl[8], 1'b1);
      run_body(tbl[8]);
      complete();
    end
    chk("wrap", 32'(run_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
